// File: rtl/w_seq_pkg.sv
// Shared constants for the w pattern transmitter and its detector predictor.
//   ST_A..ST_E : bit positions of the one-hot detector state {E,D,C,B,A}
//   PRED_RESET : one-hot reset state (A)
//   IDLE/SHIFT/DONE : transmitter control FSM encoding
package w_seq_pkg;

  localparam int ST_A = 0;
  localparam int ST_B = 1;
  localparam int ST_C = 2;
  localparam int ST_D = 3;
  localparam int ST_E = 4;

  localparam logic [4:0] PRED_RESET = 5'b00001;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/w_seq_predictor.sv
// One-hot Moore model of the two-in-a-row sequence detector.
//   clk, reset : clock, synchronous active-high reset (state -> A)
//   clr        : return to state A next cycle
//   adv        : consume the current w bit
//   w          : bit under test
//   state      : registered one-hot state {E,D,C,B,A}
//   z          : C|E of the registered state
module w_seq_predictor
  import w_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       adv,
  input  logic       w,
  output logic [4:0] state,
  output logic       z
);

  logic [4:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = PRED_RESET;
    end else if (adv) begin
      state_d[ST_A] = 1'b0;
      state_d[ST_B] = ~w & (state_q[ST_A] | state_q[ST_D] | state_q[ST_E]);
      state_d[ST_C] = ~w & (state_q[ST_B] | state_q[ST_C]);
      state_d[ST_D] =  w & (state_q[ST_A] | state_q[ST_B] | state_q[ST_C]);
      state_d[ST_E] =  w & (state_q[ST_D] | state_q[ST_E]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= PRED_RESET;
    else       state_q <= state_d;
  end

  assign state = state_q;
  assign z     = state_q[ST_C] | state_q[ST_E];

endmodule

// File: rtl/w_pattern_tx.sv
// Serial stimulus transmitter for the detector's w input.
// Latches a parallel pattern and shifts it out LSB first, one bit per clk,
// optionally looping, and predicts the detector's state/z alongside.
//   clk, reset        : clock, synchronous active-high reset
//   start, abort      : begin a transmission / stop immediately
//   pattern, nbits    : bits to send (pattern[0] first), count 1..LEN
//   loop_en           : reload the pattern after the last bit
//   w, w_valid        : serial data and its qualifier
//   busy, done        : transmission in progress / one-cycle end pulse
//   exp_z, pred_state : predicted detector output and one-hot state
module w_pattern_tx
  import w_seq_pkg::*;
#(
  parameter int LEN   = 16,
  parameter int CNT_W = $clog2(LEN) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN-1:0]   pattern,
  input  logic [CNT_W-1:0] nbits,
  input  logic             loop_en,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done,
  output logic             exp_z,
  output logic [4:0]       pred_state
);

  logic [1:0]       fsm_q, fsm_d;
  logic [LEN-1:0]   shreg_q, shreg_d;
  logic [LEN-1:0]   pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] nb_q, nb_d;
  logic             nbits_ok;
  logic             pred_clr;
  logic             pred_adv;

  assign nbits_ok = (nbits != '0) && (nbits <= CNT_W'(LEN));

  always_comb begin
    fsm_d    = fsm_q;
    shreg_d  = shreg_q;
    pat_d    = pat_q;
    cnt_d    = cnt_q;
    nb_d     = nb_q;
    pred_clr = 1'b0;
    case (fsm_q)
      // DONE accepts start exactly like IDLE so sends can run back to back.
      IDLE, DONE: begin
        fsm_d = IDLE;
        if (start) begin
          if (nbits_ok) begin
            pat_d    = pattern;
            nb_d     = nbits;
            shreg_d  = pattern;
            cnt_d    = '0;
            fsm_d    = SHIFT;
            pred_clr = 1'b1;
          end else begin
            // Empty/oversized request: nothing sent, but the requester
            // still gets its done pulse. DONE is output-identical to an
            // IDLE cycle with done high.
            fsm_d = DONE;
          end
        end
      end
      SHIFT: begin
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q + CNT_W'(1) == nb_q) begin
          if (loop_en) begin
            shreg_d = pat_q;
            cnt_d   = '0;
          end else begin
            fsm_d = DONE;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
    if (abort) begin
      fsm_d    = IDLE;
      pred_clr = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q   <= IDLE;
      shreg_q <= '0;
      pat_q   <= '0;
      cnt_q   <= '0;
      nb_q    <= '0;
    end else begin
      fsm_q   <= fsm_d;
      shreg_q <= shreg_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      nb_q    <= nb_d;
    end
  end

  assign w_valid = (fsm_q == SHIFT);
  assign busy    = (fsm_q == SHIFT);
  assign done    = (fsm_q == DONE);
  assign w       = w_valid & shreg_q[0];

  // An aborted cycle's bit is treated as never delivered.
  assign pred_adv = w_valid & ~abort;

  w_seq_predictor u_pred (
    .clk   (clk),
    .reset (reset),
    .clr   (pred_clr),
    .adv   (pred_adv),
    .w     (w),
    .state (pred_state),
    .z     (exp_z)
  );

endmodule

// File: tb/tb_w_pattern_tx.sv
module tb_w_pattern_tx;

  localparam int LEN   = 16;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset, start, abort, loop_en;
  logic [LEN-1:0]   pattern;
  logic [CNT_W-1:0] nbits;
  logic             w, w_valid, busy, done, exp_z;
  logic [4:0]       pred_state;

  int checks = 0;
  int errors = 0;

  // Reference: the detector remembers only the last bit and its run length.
  int m_n, m_run;
  logic m_last;

  always #5 clk = ~clk;

  w_pattern_tx #(.LEN(LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pattern(pattern), .nbits(nbits), .loop_en(loop_en),
    .w(w), .w_valid(w_valid), .busy(busy), .done(done),
    .exp_z(exp_z), .pred_state(pred_state)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic void model_clr();
    m_n = 0; m_run = 0; m_last = 1'b0;
  endfunction

  function automatic void model_adv(logic b);
    if (m_n > 0 && b == m_last) m_run = (m_run < 2) ? m_run + 1 : 2;
    else m_run = 1;
    m_last = b;
    m_n = 1;
  endfunction

  function automatic logic [4:0] m_pred();
    if (m_n == 0) return 5'b00001;
    if (m_last) return (m_run >= 2) ? 5'b10000 : 5'b01000;
    return (m_run >= 2) ? 5'b00100 : 5'b00010;
  endfunction

  function automatic logic m_z();
    return (m_n > 0) && (m_run >= 2);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks += 6;
    if (w !== 1'b0)              begin errors++; $display("FAIL reset_w got %b exp 0", w); end
    if (w_valid !== 1'b0)        begin errors++; $display("FAIL reset_w_valid got %b exp 0", w_valid); end
    if (busy !== 1'b0)           begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (done !== 1'b0)           begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    if (exp_z !== 1'b0)          begin errors++; $display("FAIL reset_exp_z got %b exp 0", exp_z); end
    if (pred_state !== 5'b00001) begin errors++; $display("FAIL reset_pred got %b exp 00001", pred_state); end
    reset = 1'b0;
    model_clr();
    tick();
  endtask

  task automatic test_basic();
    logic [4:0] ep [5];
    logic       ez [5];
    logic       ew [4];
    ep = '{5'b00001, 5'b01000, 5'b10000, 5'b00010, 5'b00100};
    ez = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    ew = '{1'b1, 1'b1, 1'b0, 1'b0};
    pattern = 16'h0003; nbits = 5'd4; loop_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks += 4;
      if (pred_state !== ep[i]) begin errors++; $display("FAIL basic_pred[%0d] got %b exp %b", i, pred_state, ep[i]); end
      if (exp_z !== ez[i])      begin errors++; $display("FAIL basic_z[%0d] got %b exp %b", i, exp_z, ez[i]); end
      if (done !== (i == 4))    begin errors++; $display("FAIL basic_done[%0d] got %b exp %b", i, done, i == 4); end
      if (i < 4) begin
        if (w !== ew[i] || w_valid !== 1'b1) begin
          errors++; $display("FAIL basic_w[%0d] got %b/%b exp %b/1", i, w, w_valid, ew[i]);
        end
      end else if (w_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL basic_end got vld %b busy %b exp 0/0", w_valid, busy);
      end
      tick();
    end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_after got %b exp 0", done); end
    model_clr();
    model_adv(1); model_adv(1); model_adv(0); model_adv(0);
  endtask

  task automatic test_bad_nbits();
    logic [CNT_W-1:0] bad [2];
    logic [4:0] keep;
    bad = '{5'd0, 5'd17};
    for (int k = 0; k < 2; k++) begin
      keep = m_pred();
      pattern = 16'($urandom); nbits = bad[k]; start = 1'b1;
      tick();
      start = 1'b0;
      checks += 3;
      if (done !== 1'b1)       begin errors++; $display("FAIL bad_done n=%0d got %b exp 1", bad[k], done); end
      if (w_valid !== 1'b0)    begin errors++; $display("FAIL bad_vld n=%0d got %b exp 0", bad[k], w_valid); end
      if (pred_state !== keep) begin errors++; $display("FAIL bad_pred n=%0d got %b exp %b", bad[k], pred_state, keep); end
      tick();
      checks += 2;
      if (done !== 1'b0 || w_valid !== 1'b0) begin
        errors++; $display("FAIL bad_after n=%0d got done %b vld %b exp 0/0", bad[k], done, w_valid);
      end
      if (pred_state !== keep) begin errors++; $display("FAIL bad_pred2 n=%0d got %b exp %b", bad[k], pred_state, keep); end
    end
  endtask

  task automatic test_random(int trials);
    logic [15:0] p;
    int n;
    for (int t = 0; t < trials; t++) begin
      p = 16'($urandom); n = $urandom_range(1, 16);
      pattern = p; nbits = CNT_W'(n); loop_en = 1'b0; start = 1'b1;
      tick();
      start = 1'b0; pattern = 16'($urandom); nbits = CNT_W'($urandom_range(0, 16));
      model_clr();
      for (int i = 0; i <= n; i++) begin
        checks += 3;
        if (pred_state !== m_pred() || exp_z !== m_z()) begin
          errors++; $display("FAIL rnd_pred t%0d i%0d got %b/%b exp %b/%b", t, i, pred_state, exp_z, m_pred(), m_z());
        end
        if (done !== (i == n)) begin errors++; $display("FAIL rnd_done t%0d i%0d got %b exp %b", t, i, done, i == n); end
        if (i < n) begin
          if (w !== p[i] || w_valid !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL rnd_w t%0d i%0d got %b/%b/%b exp %b/1/1", t, i, w, w_valid, busy, p[i]);
          end
          model_adv(p[i]);
        end else if (w_valid !== 1'b0 || busy !== 1'b0 || w !== 1'b0) begin
          errors++; $display("FAIL rnd_end t%0d got w %b vld %b busy %b exp 0", t, w, w_valid, busy);
        end
        tick();
      end
    end
  endtask

  task automatic test_loop();
    logic ew [6];
    ew = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    pattern = 16'h0005; nbits = 5'd3; loop_en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    model_clr();
    for (int i = 0; i < 6; i++) begin
      checks += 3;
      if (w !== ew[i] || w_valid !== 1'b1) begin errors++; $display("FAIL loop_w[%0d] got %b/%b exp %b/1", i, w, w_valid, ew[i]); end
      if (done !== 1'b0) begin errors++; $display("FAIL loop_done[%0d] got %b exp 0", i, done); end
      if (pred_state !== m_pred()) begin errors++; $display("FAIL loop_pred[%0d] got %b exp %b", i, pred_state, m_pred()); end
      model_adv(ew[i]);
      if (i == 3) loop_en = 1'b0;
      tick();
    end
    checks += 2;
    if (done !== 1'b1 || w_valid !== 1'b0) begin errors++; $display("FAIL loop_end got done %b vld %b exp 1/0", done, w_valid); end
    if (pred_state !== m_pred() || exp_z !== m_z()) begin
      errors++; $display("FAIL loop_pred_end got %b/%b exp %b/%b", pred_state, exp_z, m_pred(), m_z());
    end
    tick();
  endtask

  task automatic test_busy_ignore();
    logic [15:0] p;
    p = 16'($urandom);
    pattern = p; nbits = 5'd6; loop_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks += 2;
      if (w !== p[i] || busy !== 1'b1) begin errors++; $display("FAIL busy_w[%0d] got %b/%b exp %b/1", i, w, busy, p[i]); end
      if (done !== 1'b0) begin errors++; $display("FAIL busy_done[%0d] got %b exp 0", i, done); end
      start   = (i == 1 || i == 2);
      pattern = ~p; nbits = 5'd3;
      tick();
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL busy_end_done got %b exp 1", done); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] p1, p2;
    p1 = 16'($urandom); p2 = 16'($urandom);
    pattern = p1; nbits = 5'd3; loop_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b_done1 got %b exp 1", done); end
    pattern = p2; nbits = 5'd4; start = 1'b1;
    tick();
    start = 1'b0;
    model_clr();
    for (int i = 0; i <= 4; i++) begin
      checks += 2;
      if (i < 4 && (w !== p2[i] || w_valid !== 1'b1)) begin
        errors++; $display("FAIL b2b_w[%0d] got %b/%b exp %b/1", i, w, w_valid, p2[i]);
      end
      if (done !== (i == 4)) begin errors++; $display("FAIL b2b_done[%0d] got %b exp %b", i, done, i == 4); end
      if (i < 4) model_adv(p2[i]);
      tick();
    end
  endtask

  task automatic test_abort();
    logic [15:0] p;
    p = 16'($urandom);
    pattern = p; nbits = 5'd8; loop_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    model_clr();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (w !== p[i] || w_valid !== 1'b1) begin errors++; $display("FAIL abort_w[%0d] got %b/%b exp %b/1", i, w, w_valid, p[i]); end
      if (i < 2) model_adv(p[i]);
      else abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    checks += 2;
    if (w !== 1'b0 || w_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_stop got w %b vld %b busy %b done %b exp 0", w, w_valid, busy, done);
    end
    if (pred_state !== m_pred()) begin errors++; $display("FAIL abort_pred got %b exp %b", pred_state, m_pred()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (done !== 1'b0 || w_valid !== 1'b0) begin errors++; $display("FAIL abort_quiet[%0d] got done %b vld %b exp 0/0", i, done, w_valid); end
      tick();
    end
    pattern = 16'h0002; nbits = 5'd2; start = 1'b1;
    tick();
    start = 1'b0;
    checks += 3;
    if (w !== 1'b0 || w_valid !== 1'b1 || pred_state !== 5'b00001) begin
      errors++; $display("FAIL abort_restart0 got %b/%b/%b exp 0/1/00001", w, w_valid, pred_state);
    end
    tick();
    if (w !== 1'b1 || w_valid !== 1'b1 || pred_state !== 5'b00010) begin
      errors++; $display("FAIL abort_restart1 got %b/%b/%b exp 1/1/00010", w, w_valid, pred_state);
    end
    tick();
    if (done !== 1'b1 || pred_state !== 5'b01000) begin
      errors++; $display("FAIL abort_restart_done got %b/%b exp 1/01000", done, pred_state);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    pattern = 16'hffff; nbits = 5'd8; loop_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks += 2;
    if (w !== 1'b0 || busy !== 1'b0 || w_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rstmid_ctl got w %b busy %b vld %b done %b exp 0", w, busy, w_valid, done);
    end
    if (pred_state !== 5'b00001 || exp_z !== 1'b0) begin
      errors++; $display("FAIL rstmid_pred got %b/%b exp 00001/0", pred_state, exp_z);
    end
    model_clr();
    tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
    pattern = '0; nbits = '0;
    model_clr();
    tick(); tick();
    test_reset();
    test_basic();
    test_bad_nbits();
    test_random(20);
    test_loop();
    test_busy_ignore();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_bad_nbits();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/w_pattern_tx.md
Name: w_pattern_tx

Overview:
Serial stimulus transmitter for the w input of the two-in-a-row sequence detector.
- Captures a parallel bit pattern and shifts it out on w, one bit per clk, LSB first.
- Optional loop mode; start/busy/done handshake.
- Built-in one-hot predictor of the detector's state and z, so any consumer can compare the detector output against the expected value cycle by cycle.

Parameters:
- LEN, 16, maximum pattern length in bits.
- CNT_W, $clog2(LEN)+1, width of the nbits port and the internal bit counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  request to transmit; sampled only when busy=0.
- abort  input  1  synchronous stop; priority over everything except reset.
- pattern  input  LEN  bits to send; pattern[0] is sent first.
- nbits  input  CNT_W  number of bits to send (1..LEN).
- loop_en  input  1  repeat the pattern continuously.
- w  output  1  serial data to the detector.
- w_valid  output  1  w carries a pattern bit this cycle.
- busy  output  1  transmission in progress.
- done  output  1  one-cycle pulse at end of a transmission.
- exp_z  output  1  predicted detector z.
- pred_state  output  5  predicted one-hot state {E,D,C,B,A}.

Behaviour:
Interface:
- One clock, clk. Reset is synchronous and active-high on port reset.

Reset values:
- w=0, w_valid=0, busy=0, done=0, exp_z=0, pred_state=5'b00001 (A).
- FSM in IDLE, counter=0.

FSM states:
- IDLE -> SHIFT when start=1 and nbits is in 1..LEN.
  - Latch pattern and nbits; clear counter; reset predictor to A.
- IDLE with start=1 and nbits=0 or nbits>LEN:
  - No bits sent; done pulses in the next cycle; stay in IDLE.
- SHIFT: w=shreg[0], w_valid=1, busy=1. Each cycle, shift right and increment counter.
- SHIFT at the last bit (counter=nbits-1):
  - If loop_en=1 (sampled in this cycle): reload the latched pattern with no gap cycle and stay in SHIFT. done does not pulse.
  - Otherwise go to DONE.
- DONE (1 cycle): done=1, busy=0, w_valid=0, w=0; then IDLE.
  - start in the DONE cycle is accepted exactly as in IDLE.

Timing:
- start accepted in cycle T -> bit i appears on w in cycle T+1+i.
- done is high in cycle T+1+nbits.

Handshake and abort:
- start while busy=1 is ignored; pattern and nbits changes during SHIFT are ignored.
- abort=1 in any state -> next cycle IDLE with w=0, w_valid=0, busy=0, no done pulse.
  - Predictor holds its state.

Predictor (Moore, mirrors the detector's one-hot FSM):
- Advances only in cycles with w_valid=1, using the current w:
  - B' = ~w & (A|D|E)
  - C' = ~w & (B|C)
  - D' = w & (A|B|C)
  - E' = w & (D|E)
  - A' = 0 after the first advance.
- Holds when w_valid=0.
- exp_z = C|E of the registered state, so it reflects bits up to the previous cycle.
- Reset mid-operation returns everything to reset values in the next cycle.

Decomposition:
- Package w_seq_pkg holds:
  - state-index constants ST_A=0 .. ST_E=4
  - PRED_RESET=5'b00001
  - FSM encoding IDLE/SHIFT/DONE
- Sub-module w_seq_predictor (clk, reset, clr, adv, w -> state[4:0], z) contains the one-hot predictor.
- The transmitter top holds the shift register, counter and control FSM.

Test Plan:
- Reset asserted mid-SHIFT -> next cycle w=0, busy=0, w_valid=0, pred_state=00001, exp_z=0.
- pattern=16'h0003, nbits=4, start at T:
  - w over T+1..T+4 = 1,1,0,0.
  - pred_state over T+1..T+5 = A,D,E,B,C.
  - exp_z over T+1..T+5 = 0,0,1,0,1.
  - done=1 only at T+5.
- nbits=0 with start -> done pulse at T+1, w_valid never set, pred_state unchanged.
- pattern=16'h0005, nbits=3, loop_en=1 for 2 passes, then 0:
  - w = 1,0,1,1,0,1 contiguous with no gap.
  - single done pulse after the sixth bit.
- start pulsed while busy with a different pattern -> output stream unchanged.
- start in the DONE cycle -> new pattern begins with no idle gap.
- abort at the third bit of an 8-bit send -> w_valid low next cycle, no done pulse, busy=0, and a following start works normally.
